// File: rtl/boot_rom_arb_pkg.sv
// Shared types for the boot ROM arbiter: port index, response pipeline
// register layout and the data value returned on error responses.
package boot_rom_arb_pkg;

  localparam int NUM_PORTS = 2;
  localparam logic [31:0] ERR_RDATA = 32'h0;

  typedef logic port_idx_t;

  typedef struct packed {
    logic      valid;
    port_idx_t port;
    logic      err;
  } resp_t;

  function automatic port_idx_t grant_index(input logic [NUM_PORTS-1:0] gnt);
    return gnt[1];
  endfunction

endpackage

// File: rtl/boot_rom_arbiter_if.sv
// Core-side request/grant/response bus shared by both ROM requesters.
// The master modport is the core side, the slave modport is the arbiter.
interface boot_rom_arbiter_if;
  import boot_rom_arb_pkg::*;

  logic [NUM_PORTS-1:0]       req_i;
  logic [NUM_PORTS-1:0][31:0] addr_i;
  logic [NUM_PORTS-1:0]       gnt_o;
  logic [NUM_PORTS-1:0]       rvalid_o;
  logic [31:0]                rdata_o;
  logic                       err_o;

  modport master (
    output req_i, addr_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, addr_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );

endinterface

// File: rtl/boot_rom_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, pointer remembers
// the last granted port and only moves when a grant is issued.
module rr_arb2
  import boot_rom_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_idx_t last;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last == 1'b1) ? 2'b01 : 2'b10;
    end
  end

  // Reset value of 1 lets port 0 win the first contended cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (|gnt) begin
      last <= grant_index(gnt);
    end
  end

endmodule

// File: rtl/boot_rom_arbiter.sv
// Boot ROM arbiter: round-robin sharing, range check and sticky post-boot lock.
// Optional per-port response counters are enabled with BOOT_ROM_ARB_CNT_EN.
module boot_rom_arbiter
  import boot_rom_arb_pkg::*;
#(
  parameter int ROM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      lock_i,
  boot_rom_arbiter_if.slave         bus,
  output logic                      locked_o,
  output logic                      rom_en_o,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [31:0]               rom_rdata_i
`ifdef BOOT_ROM_ARB_CNT_EN
  ,
  output logic [15:0]               cnt0_o,
  output logic [15:0]               cnt1_o
`endif
);

  logic [1:0]  gnt;
  logic        any_gnt;
  port_idx_t   sel;
  logic [31:0] sel_addr;
  logic        out_of_range;
  logic        access_err;
  logic [1:0]  unused_addr_lsbs;
  resp_t       resp;

  rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .req (bus.req_i),
    .gnt (gnt)
  );

  assign bus.gnt_o        = gnt;
  assign any_gnt          = |gnt;
  assign sel              = grant_index(gnt);
  assign sel_addr         = bus.addr_i[sel];
  assign unused_addr_lsbs = sel_addr[1:0];
  assign out_of_range     = |sel_addr[31:ROM_ADDR_WIDTH+2];
  // The lock register is sampled, so a grant in the lock_i cycle still completes.
  assign access_err       = out_of_range | locked_o;

  assign rom_en_o   = any_gnt & ~access_err;
  assign rom_addr_o = any_gnt ? sel_addr[ROM_ADDR_WIDTH+1:2] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_o <= 1'b0;
    end else if (lock_i) begin
      locked_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp <= '0;
    end else begin
      resp.valid <= any_gnt;
      resp.port  <= sel;
      resp.err   <= access_err;
    end
  end

  always_comb begin
    bus.rvalid_o = 2'b00;
    if (resp.valid) begin
      bus.rvalid_o[resp.port] = 1'b1;
    end
  end

  assign bus.err_o   = resp.valid & resp.err;
  assign bus.rdata_o = (resp.valid && !resp.err) ? rom_rdata_i : ERR_RDATA;

`ifdef BOOT_ROM_ARB_CNT_EN
  // Error responses are counted too; both counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_o <= 16'h0;
      cnt1_o <= 16'h0;
    end else begin
      if (bus.rvalid_o[0] && cnt0_o != 16'hFFFF) begin
        cnt0_o <= cnt0_o + 16'h1;
      end
      if (bus.rvalid_o[1] && cnt1_o != 16'hFFFF) begin
        cnt1_o <= cnt1_o + 16'h1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Scoreboard bench for boot_rom_arbiter: directed vectors push expected
// responses, a monitor pops them whenever a response slot comes due.
module tb_boot_rom_arbiter;
  import boot_rom_arb_pkg::*;

  localparam int AW = 10;

  typedef struct {
    int          due;
    logic [1:0]  rv;
    logic        err;
    logic [31:0] data;
  } exp_resp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          lock_i;
  logic          locked_o;
  logic          rom_en_o;
  logic [AW-1:0] rom_addr_o;
  logic [31:0]   rom_rdata_i = 32'h0;
`ifdef BOOT_ROM_ARB_CNT_EN
  logic [15:0]   cnt0_o;
  logic [15:0]   cnt1_o;
`endif

  boot_rom_arbiter_if bus ();

  boot_rom_arbiter #(.ROM_ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .lock_i      (lock_i),
    .bus         (bus),
    .locked_o    (locked_o),
    .rom_en_o    (rom_en_o),
    .rom_addr_o  (rom_addr_o),
    .rom_rdata_i (rom_rdata_i)
`ifdef BOOT_ROM_ARB_CNT_EN
    ,
    .cnt0_o      (cnt0_o),
    .cnt1_o      (cnt1_o)
`endif
  );

  always #5 clk = ~clk;

  int        checks = 0;
  int        errors = 0;
  int        cycle = 0;
  bit        bench_locked = 1'b0;
  exp_resp_t exp_q[$];

  function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
    if (a == 10'd4) return 32'hDEADBEEF;
    return {16'hB007, 6'h0, a};
  endfunction

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (rom_en_o) rom_rdata_i <= rom_word(rom_addr_o);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at cycle %0d", name, actual, expected, cycle);
    end
  endtask

  // Drives one request cycle, checks the combinational side and queues the response.
  task automatic applyStimulus(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                               input logic lk, input logic [1:0] exp_gnt);
    exp_resp_t   e;
    logic [31:0] a;
    logic        err;
    @(negedge clk);
    bus.req_i     = req;
    bus.addr_i[0] = a0;
    bus.addr_i[1] = a1;
    lock_i        = lk;
    #1;
    a   = exp_gnt[1] ? a1 : a0;
    err = (a[31:AW+2] != 0) || bench_locked;
    checkOutput("gnt", {30'h0, bus.gnt_o}, {30'h0, exp_gnt});
    checkOutput("rom_en", {31'h0, rom_en_o}, {31'h0, ~err});
    if (!err) checkOutput("rom_addr", {22'h0, rom_addr_o}, {22'h0, a[AW+1:2]});
    e.due  = cycle + 1;
    e.rv   = exp_gnt;
    e.err  = err;
    e.data = err ? 32'h0 : rom_word(a[AW+1:2]);
    exp_q.push_back(e);
    if (lk) bench_locked = 1'b1;
  endtask

  task automatic applyIdle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.req_i = 2'b00;
      lock_i    = 1'b0;
      #1;
      checkOutput("idle_gnt", {30'h0, bus.gnt_o}, 32'h0);
      checkOutput("idle_rom_en", {31'h0, rom_en_o}, 32'h0);
    end
  endtask

  // Monitor: a due entry demands a response this cycle, otherwise the bus must be quiet.
  initial begin
    exp_resp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0 && exp_q[0].due <= cycle) begin
        e = exp_q.pop_front();
        checkOutput("rvalid", {30'h0, bus.rvalid_o}, {30'h0, e.rv});
        checkOutput("err", {31'h0, bus.err_o}, {31'h0, e.err});
        checkOutput("rdata", bus.rdata_o, e.data);
      end else if (bus.rvalid_o != 2'b00) begin
        checkOutput("unexpected_rvalid", {30'h0, bus.rvalid_o}, 32'h0);
      end else begin
        checkOutput("quiet_rdata", bus.rdata_o, 32'h0);
      end
    end
  end

  initial begin
    #10000000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst       = 1'b1;
    lock_i    = 1'b0;
    bus.req_i = 2'b00;
    bus.addr_i = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_locked", {31'h0, locked_o}, 32'h0);
    checkOutput("reset_rvalid", {30'h0, bus.rvalid_o}, 32'h0);
    checkOutput("reset_err", {31'h0, bus.err_o}, 32'h0);
    checkOutput("reset_rom_en", {31'h0, rom_en_o}, 32'h0);
    rst = 1'b0;

    $display("[TB] port 0 single read of word 4");
    applyStimulus(2'b01, 32'h0000_0010, 32'h0, 1'b0, 2'b01);
    checkOutput("word4_addr", {22'h0, rom_addr_o}, 32'd4);
    applyIdle(2);

    $display("[TB] port 1 out-of-range read");
    applyStimulus(2'b10, 32'h0, 32'h0000_1000, 1'b0, 2'b10);
    applyIdle(2);

    $display("[TB] dual request alternation");
    applyStimulus(2'b11, 32'h0000_0020, 32'h0000_0104, 1'b0, 2'b01);
    applyStimulus(2'b11, 32'h0000_0020, 32'h0000_0104, 1'b0, 2'b10);
    applyStimulus(2'b11, 32'h0000_0024, 32'h0000_0108, 1'b0, 2'b01);
    applyStimulus(2'b11, 32'h0000_0024, 32'h0000_0108, 1'b0, 2'b10);
    applyStimulus(2'b11, 32'h0000_0FFC, 32'h0000_0003, 1'b0, 2'b01);
    applyStimulus(2'b11, 32'h0000_0FFC, 32'h0000_0003, 1'b0, 2'b10);
    applyIdle(2);

    $display("[TB] lock in the grant cycle");
    applyStimulus(2'b01, 32'h0000_0030, 32'h0, 1'b1, 2'b01);
    applyStimulus(2'b01, 32'h0000_0034, 32'h0, 1'b0, 2'b01);
    checkOutput("locked_set", {31'h0, locked_o}, 32'h1);
    applyStimulus(2'b10, 32'h0, 32'h0000_0008, 1'b0, 2'b10);
    applyIdle(3);
    checkOutput("locked_sticky", {31'h0, locked_o}, 32'h1);

    $display("[TB] reset with a response in flight");
    @(negedge clk);
    bus.req_i     = 2'b01;
    bus.addr_i[0] = 32'h0000_0040;
    #1;
    checkOutput("inflight_gnt", {30'h0, bus.gnt_o}, 32'h1);
    #2;
    rst       = 1'b1;
    bus.req_i = 2'b00;
    repeat (2) begin
      @(negedge clk);
      #1;
      checkOutput("rst_rvalid", {30'h0, bus.rvalid_o}, 32'h0);
    end
    rst          = 1'b0;
    bench_locked = 1'b0;
    #1;
    checkOutput("rst_unlocked", {31'h0, locked_o}, 32'h0);
    applyStimulus(2'b11, 32'h0000_0044, 32'h0000_0048, 1'b0, 2'b01);
    applyIdle(2);

`ifdef BOOT_ROM_ARB_CNT_EN
    $display("[TB] response counters");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("cnt0_reset", {16'h0, cnt0_o}, 32'h0);
    checkOutput("cnt1_reset", {16'h0, cnt1_o}, 32'h0);
    for (int i = 0; i < 10; i++) applyStimulus(2'b01, i * 4, 32'h0, 1'b0, 2'b01);
    applyIdle(2);
    checkOutput("cnt0_ten", {16'h0, cnt0_o}, 32'd10);
    for (int i = 10; i < 70000; i++) applyStimulus(2'b01, (i % 1024) * 4, 32'h0, 1'b0, 2'b01);
    applyIdle(2);
    checkOutput("cnt0_sat", {16'h0, cnt0_o}, 32'h0000_FFFF);
    checkOutput("cnt1_zero", {16'h0, cnt1_o}, 32'h0);
`endif

    applyIdle(3);
    checkOutput("queue_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boot_rom_arbiter.md
Name: boot_rom_arbiter

Overview:
- Shares the single-ported, 1-cycle-latency boot ROM macro between two requesters: port 0 (core instruction fetch) and port 1 (data/debug reads).
- Sits between the core-side request/grant buses and the boot ROM wrapper, driving its enable and word address.
- Adds round-robin arbitration, out-of-range error responses and a sticky post-boot lock that fences the ROM off once boot completes.

Parameters:
- ROM_ADDR_WIDTH, 10, word-address width of the ROM (ROM holds 2^ROM_ADDR_WIDTH 32-bit words).
- NUM_PORTS, 2, number of requesters; fixed at 2 in this revision.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- lock_i  in  1  pulse/level; a high level sets the sticky lock
- req_i  in  2  per-port request
- addr_i  in  2x32  per-port byte address, offset from ROM base
- gnt_o  out  2  per-port grant, combinational, same cycle as request
- rvalid_o  out  2  per-port response valid, one cycle after grant
- rdata_o  out  32  shared response data, valid with either rvalid
- err_o  out  1  response error flag, qualified by rvalid
- locked_o  out  1  current lock state
- rom_en_o  out  1  ROM chip enable
- rom_addr_o  out  ROM_ADDR_WIDTH  ROM word address
- rom_rdata_i  in  32  ROM read data, valid the cycle after rom_en_o

Behaviour:
- Reset: rvalid_o=0, err_o=0, locked_o=0, last-grant pointer=1 (port 0 wins first), response registers cleared.
  - rom_en_o, rom_addr_o and gnt_o are combinational from the requests, so they are 0 while no request is present.
- Arbitration:
  - At most one grant per cycle.
  - Single request: that port is granted.
  - Both ports requesting: the port not granted last is granted.
  - The pointer updates only on a grant.
  - A request must be held until granted; the arbiter never retracts a grant.
- Address decode:
  - Word address = addr_i[ROM_ADDR_WIDTH+1:2]; addr_i[1:0] is ignored.
  - If addr_i[31:ROM_ADDR_WIDTH+2] is nonzero, the access is out of range.
- Granted in-range access with unlocked state: rom_en_o=1 and rom_addr_o=word address in the grant cycle.
  - Next cycle: rvalid_o[port]=1, rdata_o=rom_rdata_i, err_o=0.
- Granted access while out of range or locked:
  - The grant is still given, but rom_en_o stays 0.
  - Next cycle: rvalid_o[port]=1, err_o=1, rdata_o=32'h0.
- Response pipeline:
  - The pipeline register holds port index, error flag and a valid bit.
  - Back-to-back grants every cycle are supported, giving full throughput.
  - There is no response backpressure.
- Lock:
  - locked_o is set on the clock edge after lock_i=1 and clears only on rst.
  - An access granted in the same cycle lock_i rises still completes normally; lock takes effect from the next grant.
- Reset mid-access: the in-flight response is discarded and no rvalid is produced after reset deasserts.
- rdata_o=0 whenever no rvalid_o bit is set.

Optional Feature:
- Macro: BOOT_ROM_ARB_CNT_EN.
- When defined:
  - Adds outputs cnt0_o and cnt1_o, each 16 bits.
  - Each counter increments once per rvalid on its port and saturates at 16'hFFFF.
  - Both counters reset to 0.
  - Error responses count.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package boot_rom_arb_pkg holds:
  - the response-register struct (valid, port, err);
  - localparam ERR_RDATA = 32'h0;
  - the port-index typedef.
- Sub-module rr_arb2: a two-input round-robin arbiter with req/gnt/pointer update, instantiated once.
- All remaining logic stays in the top module.

Test Plan:
- Port 0 alone reads addr 0x0000_0010 with ROM model word4=0xDEADBEEF:
  - gnt_o[0] same cycle, rom_addr_o=4;
  - next cycle rvalid_o[0]=1, rdata_o=0xDEADBEEF, err_o=0.
- Both ports request continuously for 6 cycles: grants alternate 0,1,0,1,0,1, and each rvalid follows its grant by exactly one cycle.
- Port 1 reads addr 0x0000_1000 with ROM_ADDR_WIDTH=10: out of range, so rom_en_o=0, then rvalid_o[1]=1, err_o=1, rdata_o=0.
- lock_i pulsed in the same cycle as port 0's in-range grant: that response has err_o=0; the following access returns err_o=1 and locked_o stays 1 until rst.
- rst asserted on the cycle after a grant: no rvalid_o is seen, and after release the first dual-request grant goes to port 0.
- With BOOT_ROM_ARB_CNT_EN: 70000 port-0 reads give cnt0_o=16'hFFFF (saturated) and cnt1_o=0.
